ex_fwd_unit: RTL and testbench
==============================

Name: ex_fwd_unit

Overview:
- Parametrised successor to the EX-stage operand forwarding mux.
- Resolves NUM_RS source operands of the instruction in EX against NUM_BYP ordered bypass sources (index 0 = youngest, e.g. MEM, then WB, ...).
- Captures resolved operands so they survive EX back-pressure after the bypass sources have moved on.
- Raises a stall while any operand depends on a producer whose data is not ready yet (load-use, multicycle ops). Sits between the ID/EX pipeline register and the ALU/branch unit.

Parameters:
- XLEN, 32, operand/data width
- NUM_RS, 2, number of source operands per instruction (3 for FMA-style ops)
- NUM_BYP, 2, number of bypass sources, priority by index (0 highest)
- RADDR_W, 5, register address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill the EX instruction, clear all capture state
- ex_valid_i  in  1  EX holds a valid instruction
- ex_ready_i  in  1  downstream accepts the EX instruction this cycle
- rs_addr_i  in  NUM_RS*RADDR_W  source register addresses
- rs_used_i  in  NUM_RS  operand is actually read
- rf_data_i  in  NUM_RS*XLEN  register-file values latched in ID/EX
- byp_valid_i  in  NUM_BYP  bypass source holds a register-writing instruction
- byp_rd_i  in  NUM_BYP*RADDR_W  bypass destination address
- byp_ready_i  in  NUM_BYP  bypass data is final (0 = load/multicycle still pending)
- byp_data_i  in  NUM_BYP*XLEN  bypass data
- rs_data_o  out  NUM_RS*XLEN  operands to EX
- stall_o  out  1  EX must not fire; ID/IF freeze, MEM receives a bubble
- ex_fire_o  out  1  ex_valid_i & ~stall_o & ex_ready_i

Behaviour:
- Reset: capture registers 0, cap_valid all 0, state RUN; stall_o=0, ex_fire_o=0, rs_data_o=0 while ex_valid_i=0.
- Per operand, resolution (combinational):
  - If rs_used=0 or rs_addr=0, the operand is resolved; its value is rf_data, forced to 0 for x0.
  - Otherwise, match = lowest index k with byp_valid[k] & byp_rd[k]==rs_addr.
  - No match: resolved, value rf_data.
  - Match with byp_ready[k]=1: resolved, value byp_data[k].
  - Match with byp_ready[k]=0: unresolved. A lower-priority ready match never overrides an unresolved higher-priority match.
- Capture:
  - A resolved, uncaptured operand is registered (cap_valid=1) at the clock edge of any cycle where ex_valid_i=1 and ex_fire_o=0.
  - A captured operand outputs its captured value and ignores bypass/rf changes.
  - An uncaptured operand outputs its live resolved value (zero latency).
- stall_o = ex_valid_i & (any used operand unresolved and uncaptured).
- State machine, per instruction:
  - RUN: no captures outstanding.
  - HOLD: at least one cap_valid set.
  - RUN->HOLD on any capture; HOLD->RUN on ex_fire_o or flush_i.
  - On fire, all cap_valid clear at that edge, so the next instruction starts uncaptured in the following cycle.
- flush_i has priority over capture and fire: cap_valid clear, ex_fire_o=0, stall_o=0 in that cycle.
- Simultaneous events:
  - Operand resolves in the same cycle ex_ready_i=1: it fires using the live value; no capture.
  - Both operands share the same rs_addr: identical values.
  - Two bypass sources match: the index-0 source wins.
- ex_valid_i=0: stall_o=0, no captures, state forced RUN.
- Reset mid-HOLD: all state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: EX_FWD_PERF_CNT_EN.
- Defined: adds outputs fwd_cnt_o[31:0] and stall_cnt_o[31:0].
  - fwd_cnt_o increments by 1 per fired instruction with at least one operand taken from a bypass source.
  - stall_cnt_o increments each cycle stall_o=1.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared core package:
  - bypass source struct (valid, rd, ready, data), XLEN-generic via parameter.
  - fwd_state_e {RUN, HOLD}.
  - Default NUM_BYP and source index constants MEM_BYP=0, WB_BYP=1.
- One sub-module, ex_fwd_slot: per-operand resolver + capture register, instantiated NUM_RS times. The top level owns stall_o, the FSM, fire and the perf counters.

Test Plan:
- No hazard: rs1=3, rs2=4, rf=0x11/0x22, no byp_valid -> rs_data=0x11/0x22, stall_o=0, fire the same cycle.
- Double match: byp0 rd=3 data=0xAAAA ready, byp1 rd=3 data=0xBBBB -> rs1=0xAAAA; rs1=x0 with byp0 rd=0 -> operand 0.
- Load-use: byp0 rd=5 ready=0, rs2=5 -> stall_o=1 for 1 cycle. Next cycle byp1 rd=5 ready data=0x1234 -> rs2=0x1234, fire.
- Back-pressure: rs1 forwarded from byp0=0xCAFE, ex_ready_i=0 for 3 cycles while byp0 changes to 0xDEAD -> rs1 stays 0xCAFE in HOLD; fire clears state.
- Flush in HOLD: capture rs1, assert flush_i -> ex_fire_o=0, state RUN. Next instruction sees live values.
- Perf (macro on): 2 forwarded fires + 3 stall cycles -> fwd_cnt_o=2, stall_cnt_o=3; assert rst_ni low mid-stall -> all counters/outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_fwd_pkg.sv
// Shared types and constants for the EX-stage operand forwarding unit.
package ex_fwd_pkg;

    localparam int NUM_BYP_DEF = 2;
    localparam int MEM_BYP     = 0;
    localparam int WB_BYP      = 1;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fwd_state_e;

endpackage

// File: rtl/ex_fwd_slot.sv
// One source operand: resolves it against the ordered bypass sources and
// holds the resolved value while EX is back-pressured.
module ex_fwd_slot
    import ex_fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = NUM_BYP_DEF,
    parameter int RADDR_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cap_en_i,
    input  logic                       cap_clr_i,
    input  logic                       hold_i,
    input  logic [RADDR_W-1:0]         rs_addr_i,
    input  logic                       rs_used_i,
    input  logic [XLEN-1:0]            rf_data_i,
    input  logic [NUM_BYP-1:0]         byp_valid_i,
    input  logic [NUM_BYP*RADDR_W-1:0] byp_rd_i,
    input  logic [NUM_BYP-1:0]         byp_ready_i,
    input  logic [NUM_BYP*XLEN-1:0]    byp_data_i,
    output logic [XLEN-1:0]            data_o,
    output logic                       pending_o,
    output logic                       from_byp_o,
    output logic                       cap_take_o
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd;
        logic               ready;
        logic [XLEN-1:0]    data;
    } byp_src_t;

    byp_src_t        byp [NUM_BYP];
    logic            live_res;
    logic            live_byp;
    logic [XLEN-1:0] live_val;
    logic            captured;

    logic            cap_valid_q, cap_valid_d;
    logic            cap_byp_q, cap_byp_d;
    logic [XLEN-1:0] cap_data_q, cap_data_d;

    always_comb begin
        for (int k = 0; k < NUM_BYP; k++) begin
            byp[k].valid = byp_valid_i[k];
            byp[k].rd    = byp_rd_i[k*RADDR_W +: RADDR_W];
            byp[k].ready = byp_ready_i[k];
            byp[k].data  = byp_data_i[k*XLEN +: XLEN];
        end
    end

    // Walk from the oldest source down so the youngest match is what remains;
    // a pending young match therefore masks any older ready one.
    always_comb begin
        live_res = 1'b1;
        live_byp = 1'b0;
        live_val = rf_data_i;
        if (rs_addr_i == '0) begin
            live_val = '0;
        end else if (rs_used_i) begin
            for (int k = NUM_BYP - 1; k >= MEM_BYP; k--) begin
                if (byp[k].valid && (byp[k].rd == rs_addr_i)) begin
                    live_res = byp[k].ready;
                    live_byp = byp[k].ready;
                    live_val = byp[k].ready ? byp[k].data : rf_data_i;
                end
            end
        end
    end

    assign captured   = cap_valid_q & hold_i;
    assign cap_take_o = cap_en_i & ~cap_valid_q & live_res;
    assign data_o     = captured ? cap_data_q : live_val;
    assign pending_o  = rs_used_i & ~captured & ~live_res;
    assign from_byp_o = rs_used_i & (captured ? cap_byp_q : live_byp);

    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_byp_d   = cap_byp_q;
        cap_data_d  = cap_data_q;
        if (cap_clr_i) begin
            cap_valid_d = 1'b0;
        end else if (cap_take_o) begin
            cap_valid_d = 1'b1;
            cap_byp_d   = live_byp;
            cap_data_d  = live_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_valid_q <= 1'b0;
            cap_byp_q   <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_byp_q   <= cap_byp_d;
            cap_data_q  <= cap_data_d;
        end
    end

endmodule

// File: rtl/ex_fwd_unit.sv
// EX-stage operand forwarding with capture under back-pressure and hazard stall.
// Optional performance counters are built when EX_FWD_PERF_CNT_EN is defined.
module ex_fwd_unit
    import ex_fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_RS  = 2,
    parameter int NUM_BYP = NUM_BYP_DEF,
    parameter int RADDR_W = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       ex_valid_i,
    input  logic                       ex_ready_i,
    input  logic [NUM_RS*RADDR_W-1:0]  rs_addr_i,
    input  logic [NUM_RS-1:0]          rs_used_i,
    input  logic [NUM_RS*XLEN-1:0]     rf_data_i,
    input  logic [NUM_BYP-1:0]         byp_valid_i,
    input  logic [NUM_BYP*RADDR_W-1:0] byp_rd_i,
    input  logic [NUM_BYP-1:0]         byp_ready_i,
    input  logic [NUM_BYP*XLEN-1:0]    byp_data_i,
    output logic [NUM_RS*XLEN-1:0]     rs_data_o,
    output logic                       stall_o,
    output logic                       ex_fire_o
`ifdef EX_FWD_PERF_CNT_EN
    ,
    output logic [31:0]                fwd_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    fwd_state_e      state_q, state_d;
    logic            active;
    logic            hold;
    logic            cap_en;
    logic            cap_clr;
    logic [XLEN-1:0] slot_data [NUM_RS];
    logic [NUM_RS-1:0] pending;
    logic [NUM_RS-1:0] from_byp;
    logic [NUM_RS-1:0] cap_take;

    // Outputs are forced quiet while in reset or with no instruction in EX.
    assign active    = rst_ni & ex_valid_i;
    assign hold      = (state_q == HOLD);
    assign stall_o   = active & ~flush_i & (|pending);
    assign ex_fire_o = active & ~flush_i & ~stall_o & ex_ready_i;
    assign cap_en    = ex_valid_i & ~flush_i & ~ex_fire_o;
    assign cap_clr   = flush_i | ex_fire_o | ~ex_valid_i;

    for (genvar i = 0; i < NUM_RS; i++) begin : g_slot
        ex_fwd_slot #(
            .XLEN    (XLEN),
            .NUM_BYP (NUM_BYP),
            .RADDR_W (RADDR_W)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .cap_en_i    (cap_en),
            .cap_clr_i   (cap_clr),
            .hold_i      (hold),
            .rs_addr_i   (rs_addr_i[i*RADDR_W +: RADDR_W]),
            .rs_used_i   (rs_used_i[i]),
            .rf_data_i   (rf_data_i[i*XLEN +: XLEN]),
            .byp_valid_i (byp_valid_i),
            .byp_rd_i    (byp_rd_i),
            .byp_ready_i (byp_ready_i),
            .byp_data_i  (byp_data_i),
            .data_o      (slot_data[i]),
            .pending_o   (pending[i]),
            .from_byp_o  (from_byp[i]),
            .cap_take_o  (cap_take[i])
        );
    end

    always_comb begin
        rs_data_o = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            rs_data_o[i*XLEN +: XLEN] = active ? slot_data[i] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (|cap_take) state_d = HOLD;
            HOLD:    if (ex_fire_o || flush_i) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (!ex_valid_i) state_d = RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

`ifdef EX_FWD_PERF_CNT_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters survive flush; they only track retirement and stall activity.
    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (ex_fire_o && (|from_byp)) fwd_cnt_d = fwd_cnt_q + 32'd1;
        if (stall_o) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_from_byp;
    assign unused_from_byp = |from_byp;
`endif

endmodule

// File: tb/tb_ex_fwd_unit.sv
// Self-checking bench for ex_fwd_unit: directed vector table, async reset,
// and randomized traffic against a behavioural model.
module tb_ex_fwd_unit;

    localparam int XLEN    = 32;
    localparam int NUM_RS  = 2;
    localparam int NUM_BYP = 2;
    localparam int RADDR_W = 5;

    logic                       clk;
    logic                       rst_n;
    logic                       flush;
    logic                       exValid;
    logic                       exReady;
    logic [NUM_RS*RADDR_W-1:0]  rsAddr;
    logic [NUM_RS-1:0]          rsUsed;
    logic [NUM_RS*XLEN-1:0]     rfData;
    logic [NUM_BYP-1:0]         bypValid;
    logic [NUM_BYP*RADDR_W-1:0] bypRd;
    logic [NUM_BYP-1:0]         bypReady;
    logic [NUM_BYP*XLEN-1:0]    bypData;
    logic [NUM_RS*XLEN-1:0]     rsData;
    logic                       stall;
    logic                       fire;
`ifdef EX_FWD_PERF_CNT_EN
    logic [31:0]                fwdCnt;
    logic [31:0]                stallCnt;
`endif

    int total = 0;
    int bad   = 0;

    ex_fwd_unit #(
        .XLEN    (XLEN),
        .NUM_RS  (NUM_RS),
        .NUM_BYP (NUM_BYP),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .ex_valid_i  (exValid),
        .ex_ready_i  (exReady),
        .rs_addr_i   (rsAddr),
        .rs_used_i   (rsUsed),
        .rf_data_i   (rfData),
        .byp_valid_i (bypValid),
        .byp_rd_i    (bypRd),
        .byp_ready_i (bypReady),
        .byp_data_i  (bypData),
        .rs_data_o   (rsData),
        .stall_o     (stall),
        .ex_fire_o   (fire)
`ifdef EX_FWD_PERF_CNT_EN
        ,
        .fwd_cnt_o   (fwdCnt),
        .stall_cnt_o (stallCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        valid, ready, flush;
        logic [4:0]  rs1, rs2;
        logic [1:0]  used;
        logic [31:0] rf1, rf2;
        logic [1:0]  bv, brdy;
        logic [4:0]  brd0, brd1;
        logic [31:0] bd0, bd1;
        logic [1:0]  chk;
        logic [31:0] exp1, exp2;
        logic        expStall, expFire;
    } vec_t;

    function automatic vec_t mkVec(
        input logic v, r, f,
        input logic [4:0] a1, a2, input logic [1:0] u,
        input logic [31:0] f1, f2,
        input logic [1:0] bv, brdy, input logic [4:0] d0, d1,
        input logic [31:0] x0, x1,
        input logic [1:0] chk, input logic [31:0] e1, e2,
        input logic es, ef);
        vec_t t;
        t.valid = v;  t.ready = r;  t.flush = f;
        t.rs1 = a1;   t.rs2 = a2;   t.used = u;
        t.rf1 = f1;   t.rf2 = f2;
        t.bv = bv;    t.brdy = brdy; t.brd0 = d0; t.brd1 = d1;
        t.bd0 = x0;   t.bd1 = x1;
        t.chk = chk;  t.exp1 = e1;  t.exp2 = e2;
        t.expStall = es; t.expFire = ef;
        return t;
    endfunction

    function automatic vec_t randVec();
        vec_t t;
        t = mkVec(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3) | $urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        return t;
    endfunction

    // Behavioural reference: per-operand held value plus live resolution.
    logic        mCap  [NUM_RS];
    logic [31:0] mVal  [NUM_RS];
    logic        mByp  [NUM_RS];
    logic [31:0] eLive [NUM_RS];
    logic        eRes  [NUM_RS];
    logic        eByp  [NUM_RS];
    logic [31:0] eData [NUM_RS];
    logic        eChk  [NUM_RS];
    logic        eStall, eFire;
    int unsigned mFwd, mStall;

    task automatic modelClear();
        for (int i = 0; i < NUM_RS; i++) begin
            mCap[i] = 1'b0;
            mVal[i] = '0;
            mByp[i] = 1'b0;
        end
    endtask

    task automatic modelEval();
        logic [4:0] a;
        int hit;
        bit anyPend;
        anyPend = 0;
        for (int i = 0; i < NUM_RS; i++) begin
            a = rsAddr[i*RADDR_W +: RADDR_W];
            eRes[i]  = 1'b1;
            eByp[i]  = 1'b0;
            eLive[i] = (a == 0) ? 32'h0 : rfData[i*XLEN +: XLEN];
            if (rsUsed[i] && a != 0) begin
                hit = -1;
                for (int k = 0; k < NUM_BYP; k++)
                    if (hit < 0 && bypValid[k] && bypRd[k*RADDR_W +: RADDR_W] == a) hit = k;
                if (hit >= 0) begin
                    if (bypReady[hit]) begin
                        eLive[i] = bypData[hit*XLEN +: XLEN];
                        eByp[i]  = 1'b1;
                    end else begin
                        eRes[i] = 1'b0;
                    end
                end
            end
            eData[i] = (!rst_n || !exValid) ? 32'h0 : (mCap[i] ? mVal[i] : eLive[i]);
            eChk[i]  = !rst_n || !exValid || mCap[i] || eRes[i];
            if (!mCap[i] && !eRes[i]) anyPend = 1;
        end
        eStall = rst_n && exValid && !flush && anyPend;
        eFire  = rst_n && exValid && !flush && !eStall && exReady;
    endtask

    task automatic modelAdvance();
        bit usedByp;
        usedByp = 0;
        for (int i = 0; i < NUM_RS; i++)
            if (rsUsed[i] && (mCap[i] ? mByp[i] : eByp[i])) usedByp = 1;
        if (eFire && usedByp) mFwd++;
        if (eStall) mStall++;
        if (!exValid || flush || eFire) begin
            modelClear();
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (!mCap[i] && eRes[i]) begin
                    mCap[i] = 1'b1;
                    mVal[i] = eLive[i];
                    mByp[i] = eByp[i];
                end
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exValid  = v.valid;
        exReady  = v.ready;
        flush    = v.flush;
        rsAddr   = {v.rs2, v.rs1};
        rsUsed   = v.used;
        rfData   = {v.rf2, v.rf1};
        bypValid = v.bv;
        bypReady = v.brdy;
        bypRd    = {v.brd1, v.brd0};
        bypData  = {v.bd1, v.bd0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelCheck(input string tag);
        for (int i = 0; i < NUM_RS; i++)
            if (eChk[i]) checkOutput($sformatf("%s_rs%0d", tag, i), rsData[i*XLEN +: XLEN], eData[i]);
        checkOutput({tag, "_stall"}, 32'(stall), 32'(eStall));
        checkOutput({tag, "_fire"}, 32'(fire), 32'(eFire));
`ifdef EX_FWD_PERF_CNT_EN
        checkOutput({tag, "_fwdcnt"}, fwdCnt, mFwd);
        checkOutput({tag, "_stallcnt"}, stallCnt, mStall);
`endif
    endtask

    task automatic runModelCycle(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #1;
        modelEval();
        modelCheck(tag);
        @(posedge clk);
        modelAdvance();
    endtask

    vec_t vecs[18];
    vec_t idle, v;

    initial begin
        vecs[0]  = mkVec(1,1,0, 3,4,2'b11, 32'h11,32'h22, 2'b00,2'b00, 0,0, 32'h0,32'h0,       2'b11, 32'h11,32'h22,     0,1);
        vecs[1]  = mkVec(1,1,0, 3,4,2'b11, 32'h11,32'h22, 2'b11,2'b11, 3,3, 32'hAAAA,32'hBBBB, 2'b11, 32'hAAAA,32'h22,   0,1);
        vecs[2]  = mkVec(1,1,0, 0,4,2'b11, 32'h55,32'h22, 2'b01,2'b01, 0,0, 32'h77,32'h0,      2'b11, 32'h0,32'h22,      0,1);
        vecs[3]  = mkVec(1,1,0, 3,5,2'b11, 32'h11,32'h22, 2'b01,2'b00, 5,0, 32'h0,32'h0,       2'b01, 32'h11,32'h0,      1,0);
        vecs[4]  = mkVec(1,1,0, 3,5,2'b11, 32'h99,32'h22, 2'b10,2'b10, 0,5, 32'h0,32'h1234,    2'b11, 32'h11,32'h1234,   0,1);
        vecs[5]  = mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hCAFE,32'h0,    2'b11, 32'hCAFE,32'h22,   0,0);
        vecs[6]  = mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 6,0, 32'hDEAD,32'h0,    2'b11, 32'hCAFE,32'h22,   0,0);
        vecs[7]  = mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 6,0, 32'hDEAD,32'h0,    2'b11, 32'hCAFE,32'h22,   0,0);
        vecs[8]  = mkVec(1,1,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 6,0, 32'hDEAD,32'h0,    2'b11, 32'hCAFE,32'h22,   0,1);
        vecs[9]  = mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hDEAD,32'h0,    2'b11, 32'hDEAD,32'h22,   0,0);
        vecs[10] = mkVec(1,1,1, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hBEEF,32'h0,    2'b11, 32'hDEAD,32'h22,   0,0);
        vecs[11] = mkVec(1,1,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hBEEF,32'h0,    2'b11, 32'hBEEF,32'h22,   0,1);
        vecs[12] = mkVec(0,1,0, 3,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 3,0, 32'h0,32'h0,       2'b11, 32'h0,32'h0,       0,0);
        vecs[13] = mkVec(1,1,1, 5,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 5,0, 32'h0,32'h0,       2'b10, 32'h0,32'h22,      0,0);
        vecs[14] = mkVec(1,1,0, 5,4,2'b11, 32'h11,32'h22, 2'b11,2'b10, 5,5, 32'h0,32'h4444,    2'b10, 32'h0,32'h22,      1,0);
        vecs[15] = mkVec(1,1,0, 5,4,2'b11, 32'h11,32'h22, 2'b11,2'b11, 5,5, 32'h5555,32'h4444, 2'b11, 32'h5555,32'h22,   0,1);
        vecs[16] = mkVec(1,1,0, 7,7,2'b11, 32'h70,32'h70, 2'b10,2'b10, 0,7, 32'h0,32'h7777,    2'b11, 32'h7777,32'h7777, 0,1);
        vecs[17] = mkVec(1,1,0, 5,4,2'b10, 32'h31,32'h22, 2'b01,2'b00, 5,0, 32'h0,32'h0,       2'b11, 32'h31,32'h22,     0,1);
        idle     = mkVec(0,0,0, 0,0,2'b00, 32'h0,32'h0,   2'b00,2'b00, 0,0, 32'h0,32'h0,       2'b00, 32'h0,32'h0,       0,0);

        // Reset state, with a hazard on the inputs that must not leak out.
        rst_n = 1'b0;
        applyStimulus(mkVec(1,1,0, 5,4,2'b11, 32'h11,32'h22, 2'b01,2'b00, 5,0, 32'h0,32'h0, 2'b00, 32'h0,32'h0, 0,0));
        modelClear();
        mFwd = 0;
        mStall = 0;
        @(negedge clk);
        #1;
        checkOutput("reset_rsdata_lo", rsData[31:0], 32'h0);
        checkOutput("reset_rsdata_hi", rsData[63:32], 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        checkOutput("reset_fire", 32'(fire), 32'h0);
`ifdef EX_FWD_PERF_CNT_EN
        checkOutput("reset_fwdcnt", fwdCnt, 32'h0);
        checkOutput("reset_stallcnt", stallCnt, 32'h0);
`endif
        applyStimulus(idle);
        #1 rst_n = 1'b1;
        @(posedge clk);

`ifdef EX_FWD_PERF_CNT_EN
        // Two forwarded fires then three stall cycles, then reset mid-stall.
        for (int n = 0; n < 2; n++)
            runModelCycle(mkVec(1,1,0, 3,4,2'b11, 32'h1,32'h2, 2'b01,2'b01, 3,0, 32'h100,32'h0, 2'b00, 32'h0,32'h0, 0,0), "perf_fwd");
        v = mkVec(1,1,0, 5,4,2'b11, 32'h1,32'h2, 2'b01,2'b00, 5,0, 32'h0,32'h0, 2'b00, 32'h0,32'h0, 0,0);
        for (int n = 0; n < 3; n++) runModelCycle(v, "perf_stall");
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput("perf_fwdcnt_2", fwdCnt, 32'd2);
        checkOutput("perf_stallcnt_3", stallCnt, 32'd3);
        checkOutput("perf_stall_live", 32'(stall), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("perf_rst_fwdcnt", fwdCnt, 32'h0);
        checkOutput("perf_rst_stallcnt", stallCnt, 32'h0);
        checkOutput("perf_rst_stall", 32'(stall), 32'h0);
        checkOutput("perf_rst_rsdata", rsData[31:0], 32'h0);
        modelClear();
        mFwd = 0;
        mStall = 0;
        #1 rst_n = 1'b1;
        modelEval();
        @(posedge clk);
        modelAdvance();
`endif

        runModelCycle(idle, "pre_table");

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            modelEval();
            if (vecs[i].chk[0]) checkOutput($sformatf("vec%0d_rs1", i), rsData[31:0], vecs[i].exp1);
            if (vecs[i].chk[1]) checkOutput($sformatf("vec%0d_rs2", i), rsData[63:32], vecs[i].exp2);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_fire", i), 32'(fire), 32'(vecs[i].expFire));
            @(posedge clk);
            modelAdvance();
        end

        // Asynchronous reset while holding a captured operand.
        runModelCycle(mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hCAFE,32'h0, 2'b00, 32'h0,32'h0, 0,0), "hold_cap");
        @(negedge clk);
        applyStimulus(mkVec(1,0,0, 6,4,2'b11, 32'h11,32'h22, 2'b01,2'b01, 6,0, 32'hDEAD,32'h0, 2'b00, 32'h0,32'h0, 0,0));
        #1;
        checkOutput("hold_before_reset", rsData[31:0], 32'hCAFE);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_in_hold_rs1", rsData[31:0], 32'h0);
        checkOutput("reset_in_hold_fire", 32'(fire), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("after_reset_live_rs1", rsData[31:0], 32'hDEAD);
        modelClear();
        mFwd = 0;
        mStall = 0;
        modelEval();
        @(posedge clk);
        modelAdvance();

        for (int n = 0; n < 400; n++) runModelCycle(randVec(), $sformatf("rand%0d", n));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
